// File: rtl/mem_stage.sv
// Memory-access / write-back stage: passes ALU results to the register file,
// runs loads and stores over a req/ack data-memory port and stalls upstream while busy.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_wd,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic        stall_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        misalign
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]  state;
  logic [4:0]  rd_q;
  logic [3:0]  op_q;
  logic [1:0]  lo_q;

  logic        is_load;
  logic        is_store;
  logic        aligned;
  logic [3:0]  sel_n;
  logic [31:0] wdata_n;
  logic        accept;
  logic        misal_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Decode of the instruction currently offered by the execute stage.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    aligned  = 1'b1;
    sel_n    = 4'b1111;
    wdata_n  = 32'h0;
    case (ex_memop)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        aligned = ~ex_mem_addr[0];
      end
      OP_LW: begin
        is_load = 1'b1;
        aligned = (ex_mem_addr[1:0] == 2'b00);
      end
      OP_SB: begin
        is_store = 1'b1;
        sel_n    = 4'b0001 << ex_mem_addr[1:0];
        wdata_n  = {4{ex_store_data[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        aligned  = ~ex_mem_addr[0];
        sel_n    = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n  = {2{ex_store_data[15:0]}};
      end
      OP_SW: begin
        is_store = 1'b1;
        aligned  = (ex_mem_addr[1:0] == 2'b00);
        wdata_n  = ex_store_data;
      end
      default: ;
    endcase
  end

  assign accept  = (state == S_IDLE) && ex_valid && (is_load || is_store) && aligned;
  assign misal_n = (state == S_IDLE) && ex_valid && (is_load || is_store) && !aligned;

  // Upstream is released in the same cycle the ack arrives.
  assign stall_req = (state == S_BUSY) ? !mem_ack : accept;

  always_comb begin
    ld_byte = 8'h0;
    case (lo_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ;
    endcase
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_val  = mem_rdata;
    case (op_q)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'h0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'h0, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_sel   <= 4'h0;
      mem_wdata <= 32'h0;
      rd_q      <= 5'h0;
      op_q      <= 4'h0;
      lo_q      <= 2'h0;
      wb_we     <= 1'b0;
      wb_waddr  <= 5'h0;
      wb_wdata  <= 32'h0;
      misalign  <= 1'b0;
    end else begin
      wb_we    <= 1'b0;
      wb_waddr <= 5'h0;
      wb_wdata <= 32'h0;
      misalign <= misal_n;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {ex_mem_addr[31:2], 2'b00};
            mem_sel   <= sel_n;
            mem_wdata <= wdata_n;
            rd_q      <= ex_wd;
            op_q      <= ex_memop;
            lo_q      <= ex_mem_addr[1:0];
          end else if (ex_valid && !is_load && !is_store) begin
            wb_we    <= ex_wreg;
            wb_waddr <= ex_wd;
            wb_wdata <= ex_wdata;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            if (!mem_we) begin
              wb_we    <= 1'b1;
              wb_waddr <= rd_q;
              wb_wdata <= ld_val;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
